// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback arbiter bus: requesters, issue/hazard lookup, write port
//
// Purpose: groups every non-clock, non-reset signal of regfile_wb_arbiter.
// Signals:
//   ReqA_Valid/Ready/Reg/Data  requester A (ALU path) handshake and payload
//   ReqB_Valid/Ready/Reg/Data  requester B (load/mul path) handshake and payload
//   Iss_Valid/Iss_Reg          destination of the instruction issuing this cycle
//   RA/RB, BusyA/BusyB         hazard lookup addresses and their busy bits
//   Busy_Vec                   registered busy scoreboard, one bit per register
//   RegWr/RW/BusW              registered register-file write port
// Modports: slave = arbiter side, master = requester/pipeline side.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  localparam int NREGS = 2 ** ADDR_W;

  logic              ReqA_Valid;
  logic              ReqA_Ready;
  logic [ADDR_W-1:0] ReqA_Reg;
  logic [DATA_W-1:0] ReqA_Data;

  logic              ReqB_Valid;
  logic              ReqB_Ready;
  logic [ADDR_W-1:0] ReqB_Reg;
  logic [DATA_W-1:0] ReqB_Data;

  logic              Iss_Valid;
  logic [ADDR_W-1:0] Iss_Reg;

  logic [ADDR_W-1:0] RA;
  logic [ADDR_W-1:0] RB;
  logic              BusyA;
  logic              BusyB;
  logic [NREGS-1:0]  Busy_Vec;

  logic              RegWr;
  logic [ADDR_W-1:0] RW;
  logic [DATA_W-1:0] BusW;

  modport slave (
    input  ReqA_Valid, ReqA_Reg, ReqA_Data,
    input  ReqB_Valid, ReqB_Reg, ReqB_Data,
    input  Iss_Valid, Iss_Reg, RA, RB,
    output ReqA_Ready, ReqB_Ready,
    output BusyA, BusyB, Busy_Vec,
    output RegWr, RW, BusW
  );

  modport master (
    output ReqA_Valid, ReqA_Reg, ReqA_Data,
    output ReqB_Valid, ReqB_Reg, ReqB_Data,
    output Iss_Valid, Iss_Reg, RA, RB,
    input  ReqA_Ready, ReqB_Ready,
    input  BusyA, BusyB, Busy_Vec,
    input  RegWr, RW, BusW
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between two writeback requesters
//
// Purpose: arbitrates requesters A and B (round-robin or A-first) onto a
// registered single write port, and keeps a per-register busy scoreboard
// for read-operand hazard checks.
// Ports:
//   Clk    clock, all state changes on posedge
//   Reset  synchronous active-high reset
//   bus    regfile_wb_arbiter_if.slave (handshakes, issue, hazard lookup, write port)
module regfile_wb_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int PRIORITY_RR = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  regfile_wb_arbiter_if.slave   bus
);
  localparam int NREGS = 2 ** ADDR_W;

  // 1 = B was granted last; resets to B so A wins the first conflict
  logic              r_last_gnt_b;
  logic              r_reg_wr;
  logic [ADDR_W-1:0] r_rw;
  logic [DATA_W-1:0] r_busw;
  logic [NREGS-1:0]  r_busy;

  logic              w_gnt_a;
  logic              w_gnt_b;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_xfer_reg;
  logic [DATA_W-1:0] w_xfer_data;
  logic [NREGS-1:0]  w_busy_nxt;

  // Grant: at most one per cycle, never without Valid, none during reset
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!Reset) begin
      if (bus.ReqA_Valid && bus.ReqB_Valid) begin
        if ((PRIORITY_RR != 0) && !r_last_gnt_b) begin
          w_gnt_b = 1'b1;
        end else begin
          w_gnt_a = 1'b1;
        end
      end else begin
        w_gnt_a = bus.ReqA_Valid;
        w_gnt_b = bus.ReqB_Valid;
      end
    end
  end

  assign w_xfer      = w_gnt_a || w_gnt_b;
  assign w_xfer_reg  = w_gnt_b ? bus.ReqB_Reg  : bus.ReqA_Reg;
  assign w_xfer_data = w_gnt_b ? bus.ReqB_Data : bus.ReqA_Data;

  // Scoreboard next state: the clear is applied first so a same-edge issue
  // of the same register wins (a new producer is now in flight).
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_xfer) begin
      w_busy_nxt[w_xfer_reg] = 1'b0;
    end
    if (bus.Iss_Valid) begin
      w_busy_nxt[bus.Iss_Reg] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_last_gnt_b <= 1'b1;
      r_reg_wr     <= 1'b0;
      r_rw         <= '0;
      r_busw       <= '0;
      r_busy       <= '0;
    end else begin
      // Register 0 is accepted like any other but never written
      r_reg_wr <= w_xfer && (w_xfer_reg != '0);
      if (w_xfer) begin
        r_rw         <= w_xfer_reg;
        r_busw       <= w_xfer_data;
        r_last_gnt_b <= w_gnt_b;
      end
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.ReqA_Ready = w_gnt_a;
  assign bus.ReqB_Ready = w_gnt_b;
  assign bus.RegWr      = r_reg_wr;
  assign bus.RW         = r_rw;
  assign bus.BusW       = r_busw;
  assign bus.Busy_Vec   = r_busy;
  // Lookups read the registered vector only; no same-cycle bypass
  assign bus.BusyA      = r_busy[bus.RA];
  assign bus.BusyB      = r_busy[bus.RB];
endmodule
